fsk_zero_cross_demod: RTL

Receive-side counterpart of the DDS sine generator in the digital-modulation chain. Consumes a stream of signed two's-complement sine samples (the format the DDS produces), detects rising zero crossings with hysteresis, and measures the sample count between consecutive crossings. Each measured period becomes one recovered FSK symbol: a short period (high tone) is `1` and a long period (low tone) is `0`. Carrier loss is detected by counter timeout.

---
 rtl/fsk_zero_cross_demod.sv | 106 ++++++++++
 1 files changed

// File: rtl/fsk_zero_cross_demod.sv
// FSK demodulator: rising zero crossings (with hysteresis) of a signed sine stream; the sample count between crossings is decoded into symbols.
// Latency: outputs register on the edge that takes the qualifying sample, so a symbol appears 1 clk after its crossing sample.
// Backpressure: none. A valid sample is accepted on every cycle; cycles without sample_valid hold all state.
module fsk_zero_cross_demod #(
  parameter int MAG_WIDTH  = 8,
  parameter int CNT_WIDTH  = 10,
  parameter int THRESHOLD  = 192,
  parameter int MIN_PERIOD = 8,
  parameter int HYST       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_valid,
  input  logic signed [MAG_WIDTH-1:0] sample,
  output logic                        bit_valid,
  output logic                        bit_out,
  output logic        [CNT_WIDTH-1:0] period_out,
  output logic                        locked,
  output logic                        carrier_lost
);

  typedef enum logic [1:0] {IDLE, MEASURE, TRACK} state_t;

  localparam logic signed [MAG_WIDTH-1:0] HYST_POS = MAG_WIDTH'(HYST);
  localparam logic signed [MAG_WIDTH-1:0] HYST_NEG = MAG_WIDTH'(-HYST);
  localparam logic [CNT_WIDTH-1:0]        CNT_MAX  = '1;
  localparam logic [CNT_WIDTH:0]          MIN_EXT  = (CNT_WIDTH+1)'(MIN_PERIOD);
  localparam logic [CNT_WIDTH:0]          THR_EXT  = (CNT_WIDTH+1)'(THRESHOLD);

  state_t               state;
  logic                 pos;
  logic [CNT_WIDTH-1:0] count;

  logic                 pos_next;
  logic                 rising;
  logic                 cnt_sat;
  logic                 accept;
  logic [CNT_WIDTH:0]   period_ext;

  // Sign tracking with a deadband, plus the crossing/period terms derived from it.
  // period_ext is one bit wider so count+1 cannot wrap before it is compared.
  always_comb begin
    pos_next = pos;
    if (sample >= HYST_POS) begin
      pos_next = 1'b1;
    end else if (sample <= HYST_NEG) begin
      pos_next = 1'b0;
    end
    rising     = ~pos & pos_next;
    cnt_sat    = (count == CNT_MAX);
    period_ext = (CNT_WIDTH+1)'(count) + (CNT_WIDTH+1)'(1);
    accept     = rising && (period_ext >= MIN_EXT);
  end

  // Arm/measure/track state machine with registered symbol outputs.
  // A timeout is checked before a crossing, so it wins when both land on one sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pos          <= 1'b1;
      count        <= '0;
      bit_valid    <= 1'b0;
      bit_out      <= 1'b0;
      period_out   <= '0;
      locked       <= 1'b0;
      carrier_lost <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      if (sample_valid) begin
        pos <= pos_next;
        case (state)
          IDLE: begin
            count <= '0;
            if (rising) begin
              state <= MEASURE;
            end
          end
          MEASURE, TRACK: begin
            if (cnt_sat) begin
              state        <= IDLE;
              count        <= '0;
              carrier_lost <= 1'b1;
              locked       <= 1'b0;
            end else if (accept) begin
              state        <= TRACK;
              count        <= '0;
              period_out   <= period_ext[CNT_WIDTH-1:0];
              bit_out      <= (period_ext < THR_EXT);
              bit_valid    <= 1'b1;
              carrier_lost <= 1'b0;
              locked       <= 1'b1;
            end else begin
              // Not saturated here, so a plain increment cannot wrap.
              count <= count + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            count <= '0;
          end
        endcase
      end
    end
  end

endmodule
